// File: rtl/writeback_stage.sv
// writeback_stage: MIPS writeback stage, FIFO-buffered register-file write port with retired-instruction counter
// Optional WB_BYPASS_EN adds a combinational forwarding lookup for Decode.
module writeback_stage #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_reg_write,
    input  logic             in_mem_to_reg,
    input  logic             in_reg_dst,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [31:0]      in_alu_result,
    input  logic [31:0]      in_mem_data,
    input  logic [2:0]       in_load_type,
    input  logic             wb_stall,
    output logic             RegWrite,
    output logic [4:0]       write_reg,
    output logic [31:0]      write_data,
    output logic [CNT_W-1:0] retired_count
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]       bypass_reg,
    output logic             bypass_hit,
    output logic [31:0]      bypass_data
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [37:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          push, pop, we_v;
    logic [4:0]    dest;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   load_v, data_v;

    assign in_ready = count != CW'(FIFO_DEPTH);
    assign push     = in_valid && in_ready;
    assign pop      = count != '0 && !wb_stall;

    // Destination, load extension and write enable are resolved before the entry is stored
    always_comb begin
        dest   = in_reg_dst ? in_rd : in_rt;
        byte_v = 8'(in_mem_data >> {~in_alu_result[1:0], 3'b000});
        half_v = in_alu_result[1] ? in_mem_data[15:0] : in_mem_data[31:16];
        load_v = in_load_type == 3'd1 ? {{24{byte_v[7]}}, byte_v} :
                 in_load_type == 3'd2 ? {24'b0, byte_v} :
                 in_load_type == 3'd3 ? {{16{half_v[15]}}, half_v} :
                 in_load_type == 3'd4 ? {16'b0, half_v} : in_mem_data;
        data_v = in_mem_to_reg ? load_v : in_alu_result;
        we_v   = in_reg_write && dest != 5'd0;
    end

    // Entry storage needs no reset: occupancy is tracked by count alone
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= {we_v, dest, data_v};
    end

    // Queue pointers, occupancy and the registered write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            RegWrite      <= 1'b0;
            write_reg     <= '0;
            write_data    <= '0;
            retired_count <= '0;
        end else begin
            if (pop) begin
                {RegWrite, write_reg, write_data} <= mem[head];
                head          <= head + AW'(1);
                retired_count <= retired_count + CNT_W'(1);
            end else begin
                RegWrite <= 1'b0;
            end
            if (push) tail <= tail + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef WB_BYPASS_EN
    // Oldest-to-youngest scan so the youngest matching write wins; output regs are oldest of all
    always_comb begin
        bypass_hit  = RegWrite && write_reg == bypass_reg;
        bypass_data = write_data;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (CW'(i) < count && mem[head + AW'(i)][37] && mem[head + AW'(i)][36:32] == bypass_reg) begin
                bypass_hit  = 1'b1;
                bypass_data = mem[head + AW'(i)][31:0];
            end
        end
        if (bypass_reg == 5'd0) bypass_hit = 1'b0;
    end
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: scoreboard bench for writeback_stage with a queue-based reference model
module tb_writeback_stage;
    localparam int D = 2;

    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_reg_write = 0, in_mem_to_reg = 0, in_reg_dst = 0, wb_stall = 0;
    logic [4:0]  in_rt = 0, in_rd = 0;
    logic [31:0] in_alu_result = 0, in_mem_data = 0;
    logic [2:0]  in_load_type = 0;
    logic        in_ready, RegWrite;
    logic [4:0]  write_reg;
    logic [31:0] write_data, retired_count;
`ifdef WB_BYPASS_EN
    logic [4:0]  bypass_reg = 0;
    logic        bypass_hit;
    logic [31:0] bypass_data;
`endif

    writeback_stage #(.FIFO_DEPTH(D), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg), .in_reg_dst(in_reg_dst),
        .in_rt(in_rt), .in_rd(in_rd), .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
        .in_load_type(in_load_type), .wb_stall(wb_stall), .RegWrite(RegWrite),
        .write_reg(write_reg), .write_data(write_data), .retired_count(retired_count)
`ifdef WB_BYPASS_EN
        , .bypass_reg(bypass_reg), .bypass_hit(bypass_hit), .bypass_data(bypass_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {bit we; bit [4:0] d; bit [31:0] v;} ent_t;
    typedef struct {bit rw; bit [4:0] r; bit [31:0] v; bit [31:0] cnt; bit rdy;} exp_t;

    ent_t       q[$];
    exp_t       sb[$];
    ent_t       x;
    exp_t       e, em;
    bit         m_rw, pop_m, push_m, fire;
    bit [4:0]   m_reg, dst;
    bit [31:0]  m_data, m_cnt;
    int         checks = 0, errors = 0;

    task automatic chk(string n, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", n, act, req, $time);
        end
    endtask

    // Reference load semantics written from the byte/halfword numbering rules
    function automatic bit [31:0] ref_data(bit m2r, bit [2:0] lt, bit [31:0] alu, bit [31:0] mem);
        int off;
        bit [31:0] b, h;
        if (!m2r) return alu;
        off = int'(alu[1:0]);
        b = (mem >> (8 * (3 - off))) & 32'hFF;
        h = alu[1] ? (mem & 32'hFFFF) : (mem >> 16);
        case (lt)
            3'd1:    return b >= 128 ? b - 256 : b;
            3'd2:    return b;
            3'd3:    return h >= 32768 ? h - 65536 : h;
            3'd4:    return h;
            default: return mem;
        endcase
    endfunction

    // Model: decides pop/push from its own occupancy and queues one expectation per edge
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_rw = 0; m_reg = 0; m_data = 0; m_cnt = 0;
        end else begin
            pop_m  = q.size() > 0 && !wb_stall;
            push_m = in_valid && q.size() < D;
            if (pop_m) begin
                x = q.pop_front();
                m_rw = x.we; m_reg = x.d; m_data = x.v; m_cnt++;
            end else m_rw = 0;
            if (push_m) begin
                dst  = in_reg_dst ? in_rd : in_rt;
                x.we = in_reg_write && dst != 0;
                x.d  = dst;
                x.v  = ref_data(in_mem_to_reg, in_load_type, in_alu_result, in_mem_data);
                q.push_back(x);
            end
        end
        em.rw = m_rw; em.r = m_reg; em.v = m_data; em.cnt = m_cnt; em.rdy = q.size() < D;
        sb.push_back(em);
    end

    // Monitor: compares DUT outputs against the oldest queued expectation
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("RegWrite", 32'(RegWrite), 32'(e.rw));
            chk("write_reg", 32'(write_reg), 32'(e.r));
            chk("write_data", write_data, e.v);
            chk("retired_count", retired_count, e.cnt);
            chk("in_ready", 32'(in_ready), 32'(e.rdy));
`ifdef WB_BYPASS_EN
            begin
                bit h; bit [31:0] bd;
                h = m_rw && m_reg == bypass_reg; bd = m_data;
                foreach (q[i]) if (q[i].we && q[i].d == bypass_reg) begin h = 1; bd = q[i].v; end
                if (bypass_reg == 0) h = 0;
                chk("bypass_hit", 32'(bypass_hit), 32'(h));
                if (h) chk("bypass_data", bypass_data, bd);
            end
`endif
        end
    end

    task automatic set_in(bit rw, bit m2r, bit rdst, bit [4:0] rt, bit [4:0] rd, bit [31:0] alu, bit [31:0] mem, bit [2:0] lt);
        in_reg_write = rw; in_mem_to_reg = m2r; in_reg_dst = rdst; in_rt = rt; in_rd = rd;
        in_alu_result = alu; in_mem_data = mem; in_load_type = lt;
    endtask

    task automatic set_rand();
        set_in(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               $urandom, $urandom, 3'($urandom));
    endtask

    task automatic drain();
        wb_stall = 0; in_valid = 0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Single instruction into an empty stage; write must appear in the cycle after the push edge
    task automatic direct(string n, bit rw, bit m2r, bit rdst, bit [4:0] rt, bit [4:0] rd,
                          bit [31:0] alu, bit [31:0] mem, bit [2:0] lt, bit exp_rw, bit [4:0] exp_r, bit [31:0] exp_v);
        drain();
        set_in(rw, m2r, rdst, rt, rd, alu, mem, lt);
        in_valid = 1;
        @(posedge clk); #1 in_valid = 0;
        @(posedge clk); @(negedge clk);
        chk({n, "_we"}, 32'(RegWrite), 32'(exp_rw));
        chk({n, "_reg"}, 32'(write_reg), 32'(exp_r));
        chk({n, "_data"}, write_data, exp_v);
        @(negedge clk);
        chk({n, "_one_cycle"}, 32'(RegWrite), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        direct("alu", 1, 0, 1, 5'd3, 5'd5, 32'h1234_5678, 32'h0, 3'd0, 1, 5'd5, 32'h1234_5678);
        direct("lb0", 1, 1, 0, 5'd2, 5'd0, 32'h0, 32'h80FF_7F01, 3'd1, 1, 5'd2, 32'hFFFF_FF80);
        direct("lb2", 1, 1, 0, 5'd2, 5'd0, 32'h2, 32'h80FF_7F01, 3'd1, 1, 5'd2, 32'h0000_007F);
        direct("lbu1", 1, 1, 0, 5'd2, 5'd0, 32'h1, 32'h80FF_7F01, 3'd2, 1, 5'd2, 32'h0000_00FF);
        direct("lh2", 1, 1, 0, 5'd2, 5'd0, 32'h2, 32'h80FF_7F01, 3'd3, 1, 5'd2, 32'h0000_7F01);
        direct("lhu0", 1, 1, 0, 5'd2, 5'd0, 32'h0, 32'h80FF_7F01, 3'd4, 1, 5'd2, 32'h0000_80FF);
        direct("r0", 1, 0, 0, 5'd0, 5'd9, 32'hDEAD_BEEF, 32'h0, 3'd0, 0, 5'd0, 32'hDEAD_BEEF);
        chk("r0_retired", retired_count, 32'd7);

        // Stall with three back-to-back offers; the third waits for space
        drain();
        wb_stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 1, 5'd0, 5'(10 + i), 32'(100 + i), 32'h0, 3'd0);
            in_valid = 1;
            @(posedge clk); #1;
        end
        chk("full_ready", 32'(in_ready), 32'd0);
        wb_stall = 0;
        fire = 0;
        for (int t = 0; t < 10 && !fire; t++) begin
            @(posedge clk);
            fire = in_valid && in_ready;
            #1;
        end
        if (!fire) chk("stall_timeout", 32'd0, 32'd1);
        in_valid = 0;

        // Randomized traffic with intermittent stalls
        drain();
        set_rand();
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            fire = in_valid && in_ready;
            #1;
            if (fire || !in_valid) begin
                set_rand();
                in_valid = 1'($urandom_range(0, 3) != 0);
            end
            wb_stall = $urandom_range(0, 3) == 0;
`ifdef WB_BYPASS_EN
            bypass_reg = 5'($urandom_range(0, 7));
`endif
        end

`ifdef WB_BYPASS_EN
        drain();
        wb_stall = 1;
        set_in(1, 0, 1, 5'd0, 5'd7, 32'hA, 32'h0, 3'd0); in_valid = 1;
        @(posedge clk); #1 set_in(1, 0, 1, 5'd0, 5'd7, 32'hB, 32'h0, 3'd0);
        @(posedge clk); #1 in_valid = 0; bypass_reg = 7;
        @(negedge clk);
        chk("byp_hit", 32'(bypass_hit), 32'd1);
        chk("byp_data", bypass_data, 32'hB);
        #1 bypass_reg = 0;
        #1 chk("byp_r0", 32'(bypass_hit), 32'd0);
`endif

        // Asynchronous reset while two entries are pending
        drain();
        wb_stall = 1;
        set_in(1, 0, 1, 5'd0, 5'd4, 32'h55, 32'h0, 3'd0); in_valid = 1;
        repeat (2) @(posedge clk);
        #1 in_valid = 0;
        @(negedge clk); #1 rst = 1;
        #1;
        chk("rst_we", 32'(RegWrite), 32'd0);
        chk("rst_reg", 32'(write_reg), 32'd0);
        chk("rst_data", write_data, 32'd0);
        chk("rst_cnt", retired_count, 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1 rst = 0; wb_stall = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("post_rst_cnt", retired_count, 32'd0);
        chk("sb_model_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
